// File: rtl/cpu_pkg.sv
// Shared definitions for the MiniCPU control unit.
//   - opcode, ALU-op, write-back-select and FSM-state encodings
//   - instruction-register field positions
//   - decoder output record (dec_t)
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_LDI  = 4'h5,
    OP_MOV  = 4'h6,
    OP_JZ   = 4'h7,
    OP_JMP  = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'b000,
    ALU_SUB    = 3'b001,
    ALU_AND    = 3'b010,
    ALU_OR     = 3'b011,
    ALU_PASS_B = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_IMM  = 2'b01,
    WB_RSVD = 2'b10
  } wb_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam int IR_OP_HI = 7;
  localparam int IR_OP_LO = 4;
  localparam int IR_RD_HI = 3;
  localparam int IR_RD_LO = 2;
  localparam int IR_RS_HI = 1;
  localparam int IR_RS_LO = 0;

  typedef struct packed {
    logic    writes_rf;
    wb_sel_e wb_sel;
    alu_op_e alu_op;
    logic    sets_z;
    logic    is_branch;
    logic    is_cond;
    logic    is_halt;
    logic    is_illegal;
  } dec_t;

endpackage

// File: rtl/cpu_controller_if.sv
// Controller <-> instruction memory / register-file / ALU bus.
//   master : the controller (drives pc and datapath controls)
//   slave  : memory + datapath (drives instr and alu_zero)
interface cpu_controller_if #(
  parameter int PC_W = 4
);
  logic [7:0]      instr;
  logic            alu_zero;
  logic [PC_W-1:0] pc;
  logic [1:0]      rf_rd_addr1;
  logic [1:0]      rf_rd_addr2;
  logic            rf_we;
  logic [1:0]      rf_wr_addr;
  logic [2:0]      alu_op;
  logic [1:0]      wb_sel;
  logic [3:0]      imm;

  modport master (
    input  instr, alu_zero,
    output pc, rf_rd_addr1, rf_rd_addr2, rf_we, rf_wr_addr, alu_op, wb_sel, imm
  );

  modport slave (
    output instr, alu_zero,
    input  pc, rf_rd_addr1, rf_rd_addr2, rf_we, rf_wr_addr, alu_op, wb_sel, imm
  );
endinterface

// File: rtl/cpu_decoder.sv
// Combinational opcode decoder.
//   opcode : IR[7:4]
//   dec    : control record for the FSM (write class, mux/ALU selects,
//            Z update, branch kind, halt, illegal)
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADD;
    dec.wb_sel = WB_ALU;
    case (opcode)
      OP_NOP: ;
      OP_ADD: begin dec.writes_rf = 1'b1; dec.sets_z = 1'b1; dec.alu_op = ALU_ADD; end
      OP_SUB: begin dec.writes_rf = 1'b1; dec.sets_z = 1'b1; dec.alu_op = ALU_SUB; end
      OP_AND: begin dec.writes_rf = 1'b1; dec.sets_z = 1'b1; dec.alu_op = ALU_AND; end
      OP_OR:  begin dec.writes_rf = 1'b1; dec.sets_z = 1'b1; dec.alu_op = ALU_OR;  end
      OP_LDI: begin dec.writes_rf = 1'b1; dec.wb_sel = WB_IMM; end
      // MOV routes rs through the ALU but leaves Z alone
      OP_MOV: begin dec.writes_rf = 1'b1; dec.alu_op = ALU_PASS_B; end
      OP_JZ:  begin dec.is_branch = 1'b1; dec.is_cond = 1'b1; end
      OP_JMP: dec.is_branch = 1'b1;
      OP_HALT: dec.is_halt = 1'b1;
      default: dec.is_illegal = 1'b1;  // 0x9..0xE
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// MiniCPU multi-cycle control unit.
// Sequences FETCH -> DECODE -> EXEC -> WB per instruction, owns pc and Z.
//   clk, rst_n : clock, async active-low reset
//   start      : pulse; leaves IDLE/HALT, restarts at pc=0 (ignored when busy)
//   busy       : in FETCH/DECODE/EXEC/WB
//   halted     : in HALT
//   illegal    : sticky undefined-opcode flag, cleared by start/reset
//   bus        : memory/datapath bus (master side)
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int PC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  cpu_controller_if.master bus
);

  state_e          state;
  logic [7:0]      ir;
  logic [PC_W-1:0] pc_q;
  logic            z_q;
  logic            we_q;
  logic            ill_q;
  alu_op_e         alu_op_q;
  wb_sel_e         wb_sel_q;

  dec_t dec;

  cpu_decoder u_dec (
    .opcode (ir[IR_OP_HI:IR_OP_LO]),
    .dec    (dec)
  );

  logic            uses_alu;
  logic            taken;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_inc;

  // alu_op only moves for instructions that actually drive the ALU;
  // otherwise it keeps its previous value.
  assign uses_alu = dec.sets_z || (dec.writes_rf && dec.wb_sel == WB_ALU);
  assign taken    = dec.is_branch && (!dec.is_cond || z_q);
  assign target   = PC_W'(ir[IR_RD_HI:IR_RS_LO]);
  assign pc_inc   = pc_q + PC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ir       <= 8'h00;
      pc_q     <= '0;
      z_q      <= 1'b0;
      we_q     <= 1'b0;
      ill_q    <= 1'b0;
      alu_op_q <= ALU_ADD;
      wb_sel_q <= WB_ALU;
    end else begin
      we_q <= 1'b0;  // write enable lives for the WB cycle only
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state <= ST_FETCH;
            pc_q  <= '0;
            z_q   <= 1'b0;
            ill_q <= 1'b0;
          end
        end
        ST_FETCH: begin
          ir    <= bus.instr;
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (uses_alu)       alu_op_q <= dec.alu_op;
          if (dec.writes_rf)  wb_sel_q <= dec.wb_sel;
          if (dec.is_illegal) ill_q    <= 1'b1;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (dec.sets_z) z_q <= bus.alu_zero;
          we_q  <= dec.writes_rf;
          state <= ST_WB;
        end
        ST_WB: begin
          // halt and illegal both park in HALT with pc held
          if (dec.is_halt || dec.is_illegal) begin
            state <= ST_HALT;
          end else begin
            pc_q  <= taken ? target : pc_inc;
            state <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.rf_rd_addr1 = ir[IR_RD_HI:IR_RD_LO];
  assign bus.rf_rd_addr2 = ir[IR_RS_HI:IR_RS_LO];
  assign bus.rf_wr_addr  = ir[IR_RD_HI:IR_RD_LO];
  assign bus.imm         = {2'b00, ir[IR_RS_HI:IR_RS_LO]};
  assign bus.rf_we       = we_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.wb_sel      = wb_sel_q;

  assign busy    = (state == ST_FETCH) || (state == ST_DECODE) ||
                   (state == ST_EXEC)  || (state == ST_WB);
  assign halted  = (state == ST_HALT);
  assign illegal = ill_q;

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, halted, illegal;

  cpu_controller_if #(.PC_W(4)) bus ();

  cpu_controller #(.PC_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .halted  (halted),
    .illegal (illegal),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // instruction memory + register file + ALU
  logic [7:0] mem [16];
  logic [3:0] rf [4];
  logic [3:0] opa, opb, alu_y;
  int we_cnt = 0;

  assign bus.instr = mem[bus.pc];

  always_comb begin
    opa = rf[bus.rf_rd_addr1];
    opb = rf[bus.rf_rd_addr2];
    case (bus.alu_op)
      3'b000:  alu_y = opa + opb;
      3'b001:  alu_y = opa - opb;
      3'b010:  alu_y = opa & opb;
      3'b011:  alu_y = opa | opb;
      default: alu_y = opb;
    endcase
  end
  assign bus.alu_zero = (alu_y == 4'd0);

  always @(posedge clk) begin
    if (bus.rf_we) begin
      rf[bus.rf_wr_addr] <= (bus.wb_sel == 2'b01) ? bus.imm : alu_y;
      we_cnt <= we_cnt + 1;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 16; a++) mem[a] = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the FETCH negedge, returns at the next instruction's FETCH
  // (or HALT) negedge. Optional start pulse across the EXEC->WB edge.
  task automatic step_instr(input bit inj, output logic [3:0] pc_f,
                            output logic [2:0] aop, output logic we,
                            output logic [1:0] wbs, output logic [1:0] wra,
                            output logic [3:0] immv);
    pc_f = bus.pc;
    @(negedge clk);
    @(negedge clk);
    aop = bus.alu_op;
    if (inj) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    we   = bus.rf_we;
    wbs  = bus.wb_sel;
    wra  = bus.rf_wr_addr;
    immv = bus.imm;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] instr;
    logic       we;
    logic [1:0] wb_sel;
    logic [2:0] alu_op;
    logic [3:0] npc;
    logic       hlt;
    logic       ill;
  } vec_t;

  vec_t vt [12];

  logic [3:0] pc_f, immv;
  logic [2:0] aop;
  logic       we;
  logic [1:0] wbs, wra;
  int snap, n, k;

  // reference model state
  logic [3:0] m_r [4];
  logic [3:0] m_pc, nxt, res;
  logic       m_z, m_halt, m_ill, exp_we;
  logic [7:0] ins;
  logic [3:0] op;
  logic [1:0] rd, rs;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{8'h00, 1'b0, 2'd0, 3'd0, 4'd1, 1'b0, 1'b0};
    vt[1]  = '{8'h1B, 1'b1, 2'd0, 3'd0, 4'd1, 1'b0, 1'b0};
    vt[2]  = '{8'h26, 1'b1, 2'd0, 3'd1, 4'd1, 1'b0, 1'b0};
    vt[3]  = '{8'h37, 1'b1, 2'd0, 3'd2, 4'd1, 1'b0, 1'b0};
    vt[4]  = '{8'h49, 1'b1, 2'd0, 3'd3, 4'd1, 1'b0, 1'b0};
    vt[5]  = '{8'h5E, 1'b1, 2'd1, 3'd0, 4'd1, 1'b0, 1'b0};
    vt[6]  = '{8'h61, 1'b1, 2'd0, 3'd4, 4'd1, 1'b0, 1'b0};
    vt[7]  = '{8'h7C, 1'b0, 2'd0, 3'd0, 4'd1, 1'b0, 1'b0};
    vt[8]  = '{8'h89, 1'b0, 2'd0, 3'd0, 4'd9, 1'b0, 1'b0};
    vt[9]  = '{8'hF0, 1'b0, 2'd0, 3'd0, 4'd0, 1'b1, 1'b0};
    vt[10] = '{8'h95, 1'b0, 2'd0, 3'd0, 4'd0, 1'b1, 1'b1};
    vt[11] = '{8'hE3, 1'b0, 2'd0, 3'd0, 4'd0, 1'b1, 1'b1};

    clear_mem();
    do_reset();

    // reset state
    chk("rst_pc", int'(bus.pc), 0);
    chk("rst_we", int'(bus.rf_we), 0);
    chk("rst_aluop", int'(bus.alu_op), 0);
    chk("rst_wbsel", int'(bus.wb_sel), 0);
    chk("rst_rd1", int'(bus.rf_rd_addr1), 0);
    chk("rst_imm", int'(bus.imm), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_illegal", int'(illegal), 0);

    // single-instruction decode table
    for (int i = 0; i < 12; i++) begin
      clear_mem();
      mem[0] = vt[i].instr;
      do_reset();
      pulse_start();
      chk("tbl_busy", int'(busy), 1);
      step_instr(1'b0, pc_f, aop, we, wbs, wra, immv);
      chk("tbl_aluop", int'(aop), int'(vt[i].alu_op));
      chk("tbl_we", int'(we), int'(vt[i].we));
      chk("tbl_wbsel", int'(wbs), int'(vt[i].wb_sel));
      chk("tbl_wraddr", int'(wra), int'(vt[i].instr[3:2]));
      chk("tbl_imm", int'(immv), int'(vt[i].instr[1:0]));
      chk("tbl_npc", int'(bus.pc), int'(vt[i].npc));
      chk("tbl_halted", int'(halted), int'(vt[i].hlt));
      chk("tbl_illegal", int'(illegal), int'(vt[i].ill));
    end

    // LDI r1,3 / LDI r2,2 / ADD r1,r2 / HALT: halted 16 cycles after FETCH
    clear_mem();
    mem[0] = 8'h57; mem[1] = 8'h5A; mem[2] = 8'h16; mem[3] = 8'hF0;
    do_reset();
    snap = we_cnt;
    pulse_start();
    n = 0;
    while (!halted && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("prog_halt_cycle", n, 16);
    chk("prog_we_pulses", we_cnt - snap, 3);
    chk("prog_r1", int'(rf[1]), 5);
    chk("prog_r2", int'(rf[2]), 2);

    // SUB to zero then JZ 0xA -> taken
    clear_mem();
    mem[0] = 8'h57; mem[1] = 8'h25; mem[2] = 8'h7A; mem[10] = 8'hF0;
    do_reset();
    pulse_start();
    repeat (3) step_instr(1'b0, pc_f, aop, we, wbs, wra, immv);
    chk("jz_taken_pc", int'(bus.pc), 10);
    chk("jz_taken_r1", int'(rf[1]), 0);

    // nonzero SUB then JZ -> falls through
    clear_mem();
    mem[0] = 8'h57; mem[1] = 8'h59; mem[2] = 8'h26; mem[3] = 8'h7A;
    do_reset();
    pulse_start();
    repeat (4) step_instr(1'b0, pc_f, aop, we, wbs, wra, immv);
    chk("jz_nt_pc", int'(bus.pc), 4);
    chk("jz_nt_r1", int'(rf[1]), 2);

    // JMP 0xF then NOP wraps pc to 0
    clear_mem();
    mem[0] = 8'h8F;
    do_reset();
    pulse_start();
    step_instr(1'b0, pc_f, aop, we, wbs, wra, immv);
    chk("jmp_pc", int'(bus.pc), 15);
    step_instr(1'b0, pc_f, aop, we, wbs, wra, immv);
    chk("wrap_pc", int'(bus.pc), 0);

    // illegal 0xB, then restart clears the flag
    clear_mem();
    mem[0] = 8'hB7;
    do_reset();
    snap = we_cnt;
    pulse_start();
    step_instr(1'b0, pc_f, aop, we, wbs, wra, immv);
    chk("ill_we", we_cnt - snap, 0);
    chk("ill_halted", int'(halted), 1);
    chk("ill_flag", int'(illegal), 1);
    pulse_start();
    chk("ill_clr", int'(illegal), 0);
    chk("ill_restart_pc", int'(bus.pc), 0);
    chk("ill_restart_busy", int'(busy), 1);

    // reset in the WB of an ADD
    clear_mem();
    mem[0] = 8'h57; mem[1] = 8'h59; mem[2] = 8'h16; mem[3] = 8'hF0;
    do_reset();
    pulse_start();
    repeat (2) step_instr(1'b0, pc_f, aop, we, wbs, wra, immv);
    repeat (3) @(negedge clk);
    chk("mid_wb_we", int'(bus.rf_we), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", int'(bus.rf_we), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_pc", int'(bus.pc), 0);
    @(negedge clk);
    chk("mid_rst_r1", int'(rf[1]), 3);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    chk("mid_resume_pc", int'(bus.pc), 0);
    chk("mid_resume_busy", int'(busy), 1);

    // start during EXEC is ignored
    clear_mem();
    mem[0] = 8'h57; mem[1] = 8'h5A; mem[2] = 8'h16; mem[3] = 8'hF0;
    do_reset();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      step_instr(i == 1, pc_f, aop, we, wbs, wra, immv);
      chk("exec_start_pc", int'(pc_f), i);
    end
    chk("exec_start_halted", int'(halted), 1);
    chk("exec_start_r1", int'(rf[1]), 5);

    // random programs vs ISA-level model
    for (int p = 0; p < 8; p++) begin
      for (int a = 0; a < 16; a++) begin
        k = $urandom_range(0, 11);
        if (k == 9)       op = 4'hF;
        else if (k == 10) op = 4'hD;
        else if (k == 11) op = 4'h7;
        else              op = 4'(k);
        mem[a] = {op, 4'($urandom_range(0, 15))};
      end
      for (int a = 0; a < 4; a++) mem[a] = {4'h5, 2'(a), 2'($urandom_range(0, 3))};
      for (int r = 0; r < 4; r++) m_r[r] = 4'd0;
      m_pc = 4'd0; m_z = 1'b0; m_halt = 1'b0; m_ill = 1'b0;
      do_reset();
      pulse_start();
      for (int s = 0; s < 24 && !m_halt; s++) begin
        ins = mem[m_pc];
        op = ins[7:4]; rd = ins[3:2]; rs = ins[1:0];
        exp_we = 1'b0;
        nxt = m_pc + 4'd1;
        case (op)
          4'h0: ;
          4'h1, 4'h2, 4'h3, 4'h4: begin
            if (op == 4'h1)      res = m_r[rd] + m_r[rs];
            else if (op == 4'h2) res = m_r[rd] - m_r[rs];
            else if (op == 4'h3) res = m_r[rd] & m_r[rs];
            else                 res = m_r[rd] | m_r[rs];
            m_r[rd] = res; m_z = (res == 4'd0); exp_we = 1'b1;
          end
          4'h5: begin m_r[rd] = {2'b00, rs}; exp_we = 1'b1; end
          4'h6: begin m_r[rd] = m_r[rs]; exp_we = 1'b1; end
          4'h7: if (m_z) nxt = ins[3:0];
          4'h8: nxt = ins[3:0];
          4'hF: begin m_halt = 1'b1; nxt = m_pc; end
          default: begin m_halt = 1'b1; m_ill = 1'b1; nxt = m_pc; end
        endcase
        step_instr(1'b0, pc_f, aop, we, wbs, wra, immv);
        chk("rnd_pc", int'(pc_f), int'(m_pc));
        chk("rnd_we", int'(we), int'(exp_we));
        m_pc = nxt;
      end
      chk("rnd_halted", int'(halted), int'(m_halt));
      chk("rnd_illegal", int'(illegal), int'(m_ill));
      for (int r = 0; r < 4; r++) chk("rnd_reg", int'(rf[r]), int'(m_r[r]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
